// File: rtl/adc_rng_word_fifo.sv
// Multi-channel ADC RNG bit packer feeding a round-robin arbitrated, channel-tagged word FIFO.
// Optional build macro ADC_RNG_VN_DEBIAS_EN adds a per-channel von Neumann corrector ahead of each packer.
module adc_rng_word_fifo #(
  parameter int WORD_W     = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CH     = 2,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [NUM_CH-1:0]  bit_valid,
  input  logic [NUM_CH-1:0]  bit_data,
  output logic [NUM_CH-1:0]  bit_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_word,
  output logic [CH_W-1:0]    out_ch,
  output logic               full,
  output logic               empty,
  output logic [LVL_W-1:0]   level
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  logic                     clr;
  logic [NUM_CH-1:0]        vld_p1;
  logic [NUM_CH-1:0]        gnt;
  logic [NUM_CH*WORD_W-1:0] words_flat;
  logic                     any_done;
  logic [CH_W-1:0]          gnt_ch;
  logic [CH_W-1:0]          cand;
  logic [CH_W-1:0]          rr_ptr;
  logic                     push_ok;
  logic                     push;
  logic                     pop;
  logic [WORD_W-1:0]        gnt_word;

  assign clr = rst | flush;

  // Stage p0: per-channel bit packing; p1: registered word-complete flag
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0]  cnt_p0;
    logic [WORD_W-1:0] word_p0;
    logic              done_p1;
    logic              take;
    logic              emit;
    logic              emit_bit;

    assign bit_ready[g] = (cnt_p0 != CNT_W'(WORD_W));
    assign take         = bit_valid[g] & bit_ready[g];

`ifdef ADC_RNG_VN_DEBIAS_EN
    logic pair_have;
    logic pair_bit;

    // A differing pair emits its first bit: 01 -> 0, 10 -> 1
    assign emit     = take & pair_have & (pair_bit != bit_data[g]);
    assign emit_bit = pair_bit;

    always_ff @(posedge clk) begin
      if (clr)       pair_have <= 1'b0;
      else if (take) pair_have <= ~pair_have;
    end

    always_ff @(posedge clk) begin
      if (take & ~pair_have) pair_bit <= bit_data[g];
    end
`else
    assign emit     = take;
    assign emit_bit = bit_data[g];
`endif

    always_ff @(posedge clk) begin
      if (clr || gnt[g]) begin
        cnt_p0  <= '0;
        done_p1 <= 1'b0;
      end else begin
        if (emit) cnt_p0 <= cnt_p0 + 1'b1;
        if (cnt_p0 == CNT_W'(WORD_W)) done_p1 <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (emit) word_p0[cnt_p0] <= emit_bit;
    end

    assign vld_p1[g]                      = done_p1;
    assign words_flat[g*WORD_W +: WORD_W] = word_p0;
  end

  // Stage p2: round-robin grant and push into the FIFO
  always_comb begin
    any_done = 1'b0;
    gnt_ch   = '0;
    cand     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(rr_ptr) + i >= NUM_CH) cand = CH_W'(int'(rr_ptr) + i - NUM_CH);
      else                            cand = CH_W'(int'(rr_ptr) + i);
      if (!any_done && vld_p1[cand]) begin
        any_done = 1'b1;
        gnt_ch   = cand;
      end
    end
  end

  assign pop      = out_valid & out_ready;
  assign push_ok  = ~full | pop;
  assign push     = any_done & push_ok;
  assign gnt      = push ? (NUM_CH'(1) << gnt_ch) : '0;
  assign gnt_word = words_flat[int'(gnt_ch)*WORD_W +: WORD_W];

  always_ff @(posedge clk) begin
    if (clr) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
    end
  end

  logic [CH_W+WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [LVL_W-1:0]       level_r;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {gnt_ch, gnt_word};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_r <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

  assign level     = level_r;
  assign empty     = (level_r == '0);
  assign full      = (level_r == LVL_W'(FIFO_DEPTH));
  assign out_valid = ~empty;
  // Head entry is masked so stale memory never shows while empty
  assign out_word  = empty ? '0 : mem[rd_ptr][WORD_W-1:0];
  assign out_ch    = empty ? '0 : mem[rd_ptr][CH_W+WORD_W-1:WORD_W];

endmodule
